// File: rtl/seq_alu.sv
// Sequential ALU for the multicycle execute stage.
// Logic, arithmetic and compare ops finish in one cycle. Unsigned multiply
// (shift-add) and unsigned divide (restoring) take one step per cycle in CALC.
// All results are registered and held until the next op completes.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_MULU = 4'h8;
    localparam logic [3:0] OP_DIVU = 4'h9;
    localparam logic [3:0] OP_SEQ  = 4'hA;
    localparam logic [3:0] OP_SNE  = 4'hB;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, zero_q, ovf_q;
    logic [WIDTH-1:0] y_q, hi_q;

    // Iterative datapath: opnd = multiplicand/divisor, acc = partial high/remainder,
    // shr = multiplier bits still to consume / dividend bits turning into quotient.
    logic             div_q;
    logic [WIDTH-1:0] opnd_q, acc_q, shr_q;
    logic [WIDTH-1:0] acc_d, shr_d;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    logic [WIDTH-1:0] sum, dif, y_d, hi_d;
    logic             zero_d, ovf_d, multi_d, bneg_sign;

    assign sum = a + b;
    assign dif = a - b;
    // Sign of the two's-complement negation of b: 0 for b==0, 1 for the most
    // negative value (it negates to itself), otherwise the inverse of b's sign.
    assign bneg_sign = (b != '0) && (!b[WIDTH-1] || (b[WIDTH-2:0] == '0));
    // Divide by zero short-circuits to a single-cycle result.
    assign multi_d = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));

    // Single-cycle result, computed straight from the live operands.
    always_comb begin
        y_d    = '0;
        hi_d   = '0;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        case (op)
            OP_ADD: begin
                y_d   = sum;
                ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y_d   = dif;
                ovf_d = (a[WIDTH-1] == bneg_sign) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y_d = a & b;
            OP_OR:   y_d = a | b;
            OP_XOR:  y_d = a ^ b;
            OP_NOR:  y_d = ~(a | b);
            OP_SLT:  y_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULU: ;
            OP_DIVU: begin
                y_d  = '1;
                hi_d = a;
            end
            OP_SEQ:  zero_d = (a == b);
            OP_SNE:  zero_d = (a != b);
            default: zero_d = 1'b1;
        endcase
        if (op <= OP_DIVU) begin
            zero_d = (y_d == '0);
        end
    end

    // One shift-add or one restoring-divide step on the current datapath state.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, shr_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_d = div_trial[WIDTH-1:0];
                shr_d = {shr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                shr_d = {shr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
        end
    end

    // Datapath registers: load on an accepted multicycle start, step while in CALC.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start && multi_d) begin
            div_q  <= (op == OP_DIVU);
            opnd_q <= (op == OP_DIVU) ? b : a;
            shr_q  <= (op == OP_DIVU) ? a : b;
            acc_q  <= '0;
        end else if (state_q == S_CALC) begin
            acc_q <= acc_d;
            shr_q <= shr_d;
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (multi_d) begin
                            state_q <= S_CALC;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            y_q     <= y_d;
                            hi_q    <= hi_d;
                            zero_q  <= zero_d;
                            ovf_q   <= ovf_d;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        y_q     <= shr_d;
                        hi_q    <= acc_d;
                        zero_q  <= (shr_d == '0);
                        ovf_q   <= 1'b0;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign hi   = hi_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;
endmodule
